// File: rtl/ethernet_checksum_arbiter.sv
// Two-requester round-robin arbiter feeding a 64-bit one's-complement
// checksum engine; one frame at a time, result held until consumed.
module ethernet_checksum_arbiter #(
  parameter int P_MAX_BEATS = 190
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0_tvalid,
  input  logic [63:0] i_req0_tdata,
  input  logic [7:0]  i_req0_tkeep,
  input  logic        i_req0_tlast,
  input  logic [15:0] i_req0_seed,
  output logic        o_req0_tready,
  input  logic        i_req1_tvalid,
  input  logic [63:0] i_req1_tdata,
  input  logic [7:0]  i_req1_tkeep,
  input  logic        i_req1_tlast,
  input  logic [15:0] i_req1_seed,
  output logic        o_req1_tready,
  output logic [15:0] o_csum,
  output logic        o_csum_id,
  output logic        o_csum_err,
  output logic        o_csum_valid,
  input  logic        i_csum_ready
);

  localparam int LP_CW = $clog2(P_MAX_BEATS + 1);
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(P_MAX_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_FOLD,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rr;
  logic              r_grant;
  logic              r_err;
  logic [18:0]       r_acc;
  logic [LP_CW-1:0]  r_cnt;
  logic [15:0]       r_csum;
  logic              r_csum_id;
  logic              r_csum_err;
  logic              r_csum_valid;

  logic              w_busy;
  logic              w_any;
  logic              w_sel;
  logic [15:0]       w_seed;
  logic              w_tvalid;
  logic [63:0]       w_tdata;
  logic [7:0]        w_tkeep;
  logic              w_tlast;
  logic              w_hs;
  logic              w_at_max;
  logic [7:0]        w_byte [8];
  logic [15:0]       w_word [4];
  logic [18:0]       w_sum;
  logic [16:0]       w_t;
  logic [15:0]       w_f;

  assign w_busy = (r_state == S_ACCUM) || (r_state == S_DRAIN);

  assign o_req0_tready = w_busy && !r_grant;
  assign o_req1_tready = w_busy && r_grant;

  assign w_any = i_req0_tvalid || i_req1_tvalid;

  // Preferred requester wins if it is asking; otherwise the other one.
  always_comb begin
    w_sel = ~r_rr;
    if (r_rr ? i_req1_tvalid : i_req0_tvalid) begin
      w_sel = r_rr;
    end
  end

  assign w_seed   = w_sel ? i_req1_seed : i_req0_seed;
  assign w_tvalid = r_grant ? i_req1_tvalid : i_req0_tvalid;
  assign w_tdata  = r_grant ? i_req1_tdata : i_req0_tdata;
  assign w_tkeep  = r_grant ? i_req1_tkeep : i_req0_tkeep;
  assign w_tlast  = r_grant ? i_req1_tlast : i_req0_tlast;

  assign w_hs     = w_busy && w_tvalid;
  assign w_at_max = (r_cnt == LP_LAST);

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_byte[k] = w_tkeep[k] ? w_tdata[8*k +: 8] : 8'h00;
    end
  end

  // Earlier wire byte lands in the upper half of each 16-bit word.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_word[j] = {w_byte[2*j], w_byte[2*j+1]};
    end
  end

  assign w_sum = {3'b000, r_acc[15:0]}
               + {16'h0000, r_acc[18:16]}
               + {3'b000, w_word[0]}
               + {3'b000, w_word[1]}
               + {3'b000, w_word[2]}
               + {3'b000, w_word[3]};

  assign w_t = {1'b0, r_acc[15:0]} + {14'h0000, r_acc[18:16]};
  assign w_f = w_t[15:0] + {15'h0000, w_t[16]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_hs) begin
          if (w_tlast) begin
            w_next = S_FOLD;
          end else if (w_at_max) begin
            w_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_hs && w_tlast) begin
          w_next = S_FOLD;
        end
      end
      S_FOLD: begin
        w_next = S_HOLD;
      end
      S_HOLD: begin
        if (i_csum_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr         <= 1'b0;
      r_grant      <= 1'b0;
      r_err        <= 1'b0;
      r_acc        <= 19'h0;
      r_cnt        <= '0;
      r_csum       <= 16'h0;
      r_csum_id    <= 1'b0;
      r_csum_err   <= 1'b0;
      r_csum_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_acc   <= {3'b000, w_seed};
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            if (!w_tlast && w_at_max) begin
              r_err <= 1'b1;
            end
          end
        end
        S_FOLD: begin
          r_csum       <= ~w_f;
          r_csum_id    <= r_grant;
          r_csum_err   <= r_err;
          r_csum_valid <= 1'b1;
        end
        S_HOLD: begin
          if (i_csum_ready) begin
            r_csum_valid <= 1'b0;
            r_rr         <= ~r_grant;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_csum       = r_csum;
  assign o_csum_id    = r_csum_id;
  assign o_csum_err   = r_csum_err;
  assign o_csum_valid = r_csum_valid;

endmodule

// File: tb/tb_ethernet_checksum_arbiter.sv
// Directed bench for ethernet_checksum_arbiter: vector table plus
// arbitration, overflow/drain and reset sequences.
module tb_ethernet_checksum_arbiter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req0_tvalid = 1'b0;
  logic [63:0] i_req0_tdata = '0;
  logic [7:0]  i_req0_tkeep = '0;
  logic        i_req0_tlast = 1'b0;
  logic [15:0] i_req0_seed = '0;
  logic        i_req1_tvalid = 1'b0;
  logic [63:0] i_req1_tdata = '0;
  logic [7:0]  i_req1_tkeep = '0;
  logic        i_req1_tlast = 1'b0;
  logic [15:0] i_req1_seed = '0;
  logic        i_csum_ready = 1'b0;

  logic        o_req0_tready, o_req1_tready;
  logic [15:0] o_csum;
  logic        o_csum_id, o_csum_err, o_csum_valid;

  logic        m_req0_tready, m_req1_tready;
  logic [15:0] m_csum;
  logic        m_csum_id, m_csum_err, m_csum_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ethernet_checksum_arbiter u_dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_tvalid(i_req0_tvalid), .i_req0_tdata(i_req0_tdata),
    .i_req0_tkeep(i_req0_tkeep), .i_req0_tlast(i_req0_tlast),
    .i_req0_seed(i_req0_seed), .o_req0_tready(o_req0_tready),
    .i_req1_tvalid(i_req1_tvalid), .i_req1_tdata(i_req1_tdata),
    .i_req1_tkeep(i_req1_tkeep), .i_req1_tlast(i_req1_tlast),
    .i_req1_seed(i_req1_seed), .o_req1_tready(o_req1_tready),
    .o_csum(o_csum), .o_csum_id(o_csum_id), .o_csum_err(o_csum_err),
    .o_csum_valid(o_csum_valid), .i_csum_ready(i_csum_ready)
  );

  ethernet_checksum_arbiter #(.P_MAX_BEATS(4)) u_dut4 (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_tvalid(i_req0_tvalid), .i_req0_tdata(i_req0_tdata),
    .i_req0_tkeep(i_req0_tkeep), .i_req0_tlast(i_req0_tlast),
    .i_req0_seed(i_req0_seed), .o_req0_tready(m_req0_tready),
    .i_req1_tvalid(i_req1_tvalid), .i_req1_tdata(i_req1_tdata),
    .i_req1_tkeep(i_req1_tkeep), .i_req1_tlast(i_req1_tlast),
    .i_req1_seed(i_req1_seed), .o_req1_tready(m_req1_tready),
    .o_csum(m_csum), .o_csum_id(m_csum_id), .o_csum_err(m_csum_err),
    .o_csum_valid(m_csum_valid), .i_csum_ready(i_csum_ready)
  );

  typedef struct {
    bit          req;
    logic [15:0] seed;
    int          nb;
    logic [63:0] d0;
    logic [7:0]  k0;
    logic [63:0] d1;
    logic [7:0]  k1;
    logic [15:0] ec;
  } vec_t;

  vec_t        vt [6];
  logic [63:0] fd [8];
  logic [7:0]  fk [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit r, input logic v, input logic [63:0] d,
                     input logic [7:0] k, input logic l,
                     input logic [15:0] s);
    i_req0_tvalid = 1'b0;
    i_req1_tvalid = 1'b0;
    if (r) begin
      i_req1_tvalid = v; i_req1_tdata = d; i_req1_tkeep = k;
      i_req1_tlast = l; i_req1_seed = s;
    end else begin
      i_req0_tvalid = v; i_req0_tdata = d; i_req0_tkeep = k;
      i_req0_tlast = l; i_req0_seed = s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drv(1'b0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    i_csum_ready = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  // Returns right after the posedge on which the tlast beat is taken.
  task automatic send(input bit r, input logic [15:0] s, input int nb);
    int  b;
    int  cyc;
    logic hs;
    b = 0;
    cyc = 0;
    while (b < nb) begin
      @(negedge clk);
      drv(r, 1'b1, fd[b], fk[b], b == nb - 1, s);
      hs = r ? o_req1_tready : o_req0_tready;
      @(posedge clk);
      if (hs) b++;
      cyc++;
      if (cyc > 300) begin
        chk("send_timeout", 32'(b), 32'(nb));
        break;
      end
    end
  endtask

  task automatic result(input string nm, input bit d4,
                        input logic [15:0] ec, input bit eid,
                        input bit eerr, input int hold_n);
    @(negedge clk);
    drv(1'b0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    chk({nm, "_early"}, 32'(d4 ? m_csum_valid : o_csum_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(d4 ? m_csum_valid : o_csum_valid), 32'd1);
    chk({nm, "_csum"}, 32'(d4 ? m_csum : o_csum), 32'(ec));
    chk({nm, "_id"}, 32'(d4 ? m_csum_id : o_csum_id), 32'(eid));
    chk({nm, "_err"}, 32'(d4 ? m_csum_err : o_csum_err), 32'(eerr));
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk);
      chk({nm, "_hold_v"}, 32'(d4 ? m_csum_valid : o_csum_valid), 32'd1);
      chk({nm, "_hold_c"}, 32'(d4 ? m_csum : o_csum), 32'(ec));
      chk({nm, "_hold_e"}, 32'(d4 ? m_csum_err : o_csum_err), 32'(eerr));
    end
    i_csum_ready = 1'b1;
    @(negedge clk);
    i_csum_ready = 1'b0;
    chk({nm, "_clear"}, 32'(d4 ? m_csum_valid : o_csum_valid), 32'd0);
  endtask

  initial begin
    vt[0] = '{1'b0, 16'h0000, 1, 64'h0040_0000_1C00_0045, 8'hFF,
              64'h0, 8'h00, 16'h7AE3};
    vt[1] = '{1'b1, 16'h0000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h03,
              64'h0, 8'h00, 16'h0000};
    vt[2] = '{1'b0, 16'h0000, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
              64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'h0000};
    vt[3] = '{1'b0, 16'h1234, 1, 64'h0, 8'hFF,
              64'h0, 8'h00, 16'hEDCB};
    vt[4] = '{1'b1, 16'hFFFF, 1, 64'h0000_0000_0000_0001, 8'h01,
              64'h0, 8'h00, 16'hFEFF};
    vt[5] = '{1'b0, 16'h0000, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00,
              64'h0000_0000_0000_0001, 8'h01, 16'hFEFF};

    #2;
    chk("rst_tready0", 32'(o_req0_tready), 32'd0);
    chk("rst_tready1", 32'(o_req1_tready), 32'd0);
    chk("rst_csum", 32'(o_csum), 32'd0);
    chk("rst_id", 32'(o_csum_id), 32'd0);
    chk("rst_err", 32'(o_csum_err), 32'd0);
    chk("rst_valid", 32'(o_csum_valid), 32'd0);
    do_reset();

    for (int v = 0; v < 6; v++) begin
      fd[0] = vt[v].d0; fk[0] = vt[v].k0;
      fd[1] = vt[v].d1; fk[1] = vt[v].k1;
      send(vt[v].req, vt[v].seed, vt[v].nb);
      result($sformatf("vec%0d", v), 1'b0, vt[v].ec, vt[v].req, 1'b0, 0);
    end

    // Both requesters always asking: grants must alternate.
    begin
      int   idx0, idx1, nres, overlap;
      logic h0, h1;
      logic [15:0] cs [4];
      bit   ids [4];
      do_reset();
      idx0 = 0; idx1 = 0; nres = 0; overlap = 0;
      i_csum_ready = 1'b1;
      for (int c = 0; c < 200 && nres < 4; c++) begin
        @(negedge clk);
        i_req0_tvalid = 1'b1; i_req0_tdata = 64'h0; i_req0_tkeep = 8'hFF;
        i_req0_tlast = (idx0 == 1); i_req0_seed = 16'h0001;
        i_req1_tvalid = 1'b1; i_req1_tdata = 64'h0; i_req1_tkeep = 8'hFF;
        i_req1_tlast = (idx1 == 1); i_req1_seed = 16'h0002;
        h0 = o_req0_tready;
        h1 = o_req1_tready;
        if (h0 && h1) overlap++;
        if (o_csum_valid) begin
          ids[nres] = o_csum_id;
          cs[nres] = o_csum;
          nres++;
        end
        @(posedge clk);
        if (h0) idx0 = (idx0 == 1) ? 0 : idx0 + 1;
        if (h1) idx1 = (idx1 == 1) ? 0 : idx1 + 1;
      end
      chk("rr_nres", 32'(nres), 32'd4);
      chk("rr_overlap", 32'(overlap), 32'd0);
      for (int i = 0; i < nres && i < 4; i++) begin
        chk($sformatf("rr_id%0d", i), 32'(ids[i]), 32'(i % 2));
        chk($sformatf("rr_cs%0d", i), 32'(cs[i]),
            (i % 2) ? 32'h0000FFFD : 32'h0000FFFE);
      end
    end

    // Overflow at 4 beats: beats 5 and 6 are drained.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      fd[b] = 64'h0000_0000_0000_0001; fk[b] = 8'hFF;
    end
    fd[4] = 64'hFFFF_FFFF_FFFF_FFFF; fk[4] = 8'hFF;
    fd[5] = 64'hFFFF_FFFF_FFFF_FFFF; fk[5] = 8'hFF;
    send(1'b0, 16'h0000, 6);
    result("ovf", 1'b1, 16'hFBFF, 1'b0, 1'b1, 5);

    // Reset while a result is held.
    fd[0] = 64'h0; fk[0] = 8'hFF;
    send(1'b1, 16'h0005, 1);
    @(negedge clk);
    drv(1'b0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    @(negedge clk);
    chk("hold_pre_valid", 32'(o_csum_valid), 32'd1);
    #1 i_reset = 1'b1;
    #1;
    chk("hold_rst_valid", 32'(o_csum_valid), 32'd0);
    chk("hold_rst_csum", 32'(o_csum), 32'd0);
    #1 i_reset = 1'b0;

    // Reset during beat 2 of a 3-beat req1 frame.
    @(negedge clk);
    drv(1'b1, 1'b1, 64'h1, 8'hFF, 1'b0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    drv(1'b1, 1'b1, 64'h2, 8'hFF, 1'b0, 16'h0);
    chk("mid_tready_pre", 32'(o_req1_tready), 32'd1);
    #1 i_reset = 1'b1;
    i_req1_tvalid = 1'b0;
    #1;
    chk("mid_rst_tready", 32'(o_req1_tready), 32'd0);
    chk("mid_rst_valid", 32'(o_csum_valid), 32'd0);
    #1 i_reset = 1'b0;
    fd[0] = 64'h0040_0000_1C00_0045; fk[0] = 8'hFF;
    send(1'b0, 16'h0000, 1);
    result("post_rst", 1'b0, 16'h7AE3, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
